// File: rtl/sobel_stream_core.sv
// sobel_stream_core: streaming 3x3 Sobel edge detector over an IMG_W x IMG_H
// raster of PIX_W-bit pixels. Two line buffers plus a 3x3 window produce one
// result per interior pixel, 3 cycles after the pixel completing its window.
//
// Ports:
//   sys_clk    - system clock, rising edge
//   sys_rst    - synchronous active-high reset
//   pi_flag    - input pixel valid (no backpressure)
//   pi_data    - input pixel, raster order
//   th_data    - edge threshold, latched on the first pixel of each frame
//   po_flag    - output pixel valid (single-cycle pulses)
//   po_data    - edge pixel (binary threshold or saturated magnitude)
//   frame_done - high with the last po_flag of a frame
//
// Build option: define SOBEL_MAG_OUT_EN to output min(|Gx|+|Gy|, 2^PIX_W-1)
// instead of the thresholded binary edge; th_data is then ignored.
module sobel_stream_core #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int PIX_W = 8,
    localparam int MAG_W = PIX_W + 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pi_flag,
    input  logic [PIX_W-1:0] pi_data,
    input  logic [MAG_W-1:0] th_data,
    output logic             po_flag,
    output logic [PIX_W-1:0] po_data,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = MAG_W + 1;

    function automatic logic signed [SW-1:0] zx(input logic [PIX_W-1:0] p);
        return $signed({{(SW-PIX_W){1'b0}}, p});
    endfunction

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [PIX_W-1:0]       lb_a_q [IMG_W];
    logic [PIX_W-1:0]       lb_b_q [IMG_W];
    logic [PIX_W-1:0]       win_q  [3][3];
    logic [PIX_W-1:0]       rd_a, rd_b;
    logic                   accept, win_valid, last_px;
    logic                   v0_q, v1_q, v2_q;
    logic                   l0_q, l1_q, l2_q;
    logic signed [SW-1:0]   gx_q, gy_q, gx_d, gy_d, ax, ay;
    logic [MAG_W-1:0]       mag_q, mag_d;
    logic                   po_flag_q, frame_done_q;
    logic [PIX_W-1:0]       po_data_q, po_data_d;

    assign accept    = pi_flag && !sys_rst;
    assign rd_a      = lb_a_q[col_q];
    assign rd_b      = lb_b_q[col_q];
    assign win_valid = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_px   = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pi_flag) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Line buffers and window are refilled by rows 0-1 before any output, so
    // they carry no reset.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            lb_a_q[col_q] <= pi_data;
            lb_b_q[col_q] <= rd_a;
            for (int unsigned r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= rd_b;
            win_q[1][2] <= rd_a;
            win_q[2][2] <= pi_data;
        end
    end

    always_comb begin
        gx_d = (zx(win_q[0][2]) + (zx(win_q[1][2]) <<< 1) + zx(win_q[2][2]))
             - (zx(win_q[0][0]) + (zx(win_q[1][0]) <<< 1) + zx(win_q[2][0]));
        gy_d = (zx(win_q[0][0]) + (zx(win_q[0][1]) <<< 1) + zx(win_q[0][2]))
             - (zx(win_q[2][0]) + (zx(win_q[2][1]) <<< 1) + zx(win_q[2][2]));
        ax    = gx_q[SW-1] ? -gx_q : gx_q;
        ay    = gy_q[SW-1] ? -gy_q : gy_q;
        mag_d = ax[MAG_W-1:0] + ay[MAG_W-1:0];
    end

`ifdef SOBEL_MAG_OUT_EN
    logic unused_th;
    assign unused_th = ^th_data;

    always_comb begin
        po_data_d = (mag_q[MAG_W-1:PIX_W] != '0) ? '1 : mag_q[PIX_W-1:0];
    end
`else
    logic [MAG_W-1:0] thr_q, thr1_q, thr2_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            thr_q <= '0;
        end else if (pi_flag && row_q == '0 && col_q == '0) begin
            thr_q <= th_data;
        end
    end

    // The threshold travels with the pixel so the tail of one frame keeps its
    // own threshold even when the next frame starts immediately behind it.
    always_ff @(posedge sys_clk) begin
        thr1_q <= thr_q;
        thr2_q <= thr1_q;
    end

    always_comb begin
        po_data_d = (mag_q >= thr2_q) ? '1 : '0;
    end
`endif

    always_ff @(posedge sys_clk) begin
        gx_q  <= gx_d;
        gy_q  <= gy_d;
        mag_q <= mag_d;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            l0_q         <= 1'b0;
            l1_q         <= 1'b0;
            l2_q         <= 1'b0;
            po_flag_q    <= 1'b0;
            po_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            v0_q         <= pi_flag && win_valid;
            l0_q         <= pi_flag && last_px;
            v1_q         <= v0_q;
            l1_q         <= l0_q;
            v2_q         <= v1_q;
            l2_q         <= l1_q;
            po_flag_q    <= v2_q;
            po_data_q    <= po_data_d;
            frame_done_q <= l2_q;
        end
    end

    assign po_flag    = po_flag_q;
    assign po_data    = po_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_stream_core.sv
module tb_sobel_stream_core;

    localparam int SMW = 4;
    localparam int SMH = 4;
    localparam int LGW = 100;
    localparam int LGH = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pif [2];
    logic [7:0]  pid [2];
    logic [10:0] th  [2];
    logic        pof [2];
    logic [7:0]  pod [2];
    logic        fd  [2];

    always #5 clk = ~clk;

    sobel_stream_core #(.IMG_W(SMW), .IMG_H(SMH), .PIX_W(8)) dut_s (
        .sys_clk(clk), .sys_rst(rst), .pi_flag(pif[0]), .pi_data(pid[0]),
        .th_data(th[0]), .po_flag(pof[0]), .po_data(pod[0]), .frame_done(fd[0])
    );

    sobel_stream_core #(.IMG_W(LGW), .IMG_H(LGH), .PIX_W(8)) dut_l (
        .sys_clk(clk), .sys_rst(rst), .pi_flag(pif[1]), .pi_data(pid[1]),
        .th_data(th[1]), .po_flag(pof[1]), .po_data(pod[1]), .frame_done(fd[1])
    );

    typedef struct {
        int     dut;
        int     val;
        longint due;
        bit     last;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     img [LGW*LGH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: direct Sobel convolution on the stored image around the centre.
    function automatic int model(input int w, input int cr, input int cc, input int thr);
        int p [3][3];
        int gx, gy, mag;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[(cr - 1 + i) * w + (cc - 1 + j)];
        gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy  = (p[0][0] + 2 * p[0][1] + p[0][2]) - (p[2][0] + 2 * p[2][1] + p[2][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_MAG_OUT_EN
        return (mag > 255) ? 255 : mag + 0 * thr;
`else
        return (mag >= thr) ? 255 : 0;
`endif
    endfunction

    // Output monitor: po_flag must rise exactly at the due cycle of the oldest
    // expected result; frame_done must be low whenever no output is due.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit expf;
            expf = (q.size() > 0) && (q[0].dut == d) && (q[0].due == cyc);
            check($sformatf("po_flag[%0d]", d), {31'b0, pof[d]}, {31'b0, expf});
            if (expf) begin
                mon_e = q.pop_front();
                check($sformatf("po_data[%0d]", d), {24'b0, pod[d]}, mon_e.val);
                check($sformatf("frame_done[%0d]", d), {31'b0, fd[d]}, {31'b0, mon_e.last});
            end else begin
                check($sformatf("frame_done_idle[%0d]", d), {31'b0, fd[d]}, 32'd0);
            end
        end
    end

    task automatic fill(input int mode, input int w, input int h);
        for (int idx = 0; idx < w * h; idx++) begin
            int c;
            c = idx % w;
            case (mode)
                0:       img[idx] = 'h55;
                1:       img[idx] = c * 10;
                2:       img[idx] = (c >= 2) ? 255 : 0;
                default: img[idx] = $urandom_range(0, 255);
            endcase
        end
    endtask

    // gap < 0 selects a random 0..2 idle cycles after each pixel.
    task automatic send_frame(input int d, input int w, input int h, input int gap,
                              input bit expect_out, input int npix, input bit chg_thr);
        int thr_frame;
        thr_frame = 0;
        for (int idx = 0; idx < npix; idx++) begin
            int r, c, g;
            r = idx / w;
            c = idx % w;
            if (chg_thr && idx == npix / 2) th[d] = 11'($urandom_range(0, 1500));
            if (idx == 0) thr_frame = int'(th[d]);
            pif[d] = 1'b1;
            pid[d] = 8'(img[idx]);
            @(posedge clk); #1;
            if (expect_out && r >= 2 && c >= 2)
                q.push_back('{d, model(w, r - 1, c - 1, thr_frame), cyc + 3, idx == w * h - 1});
            pif[d] = 1'b0;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        repeat (8) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pif[d] = 1'b0;
            pid[d] = '0;
            th[d]  = '0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_po_flag", {31'b0, pof[d]}, 32'd0);
            check("reset_po_data", {24'b0, pod[d]}, 32'd0);
            check("reset_frame_done", {31'b0, fd[d]}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Flat image: no edges anywhere.
        fill(0, SMW, SMH); th[0] = 11'd1;
        send_frame(0, SMW, SMH, 0, 1'b1, SMW * SMH, 1'b0); drain();

        // Ramp: mag = 80 at every centre, threshold on both sides of it.
        fill(1, SMW, SMH); th[0] = 11'd80;
        send_frame(0, SMW, SMH, 0, 1'b1, SMW * SMH, 1'b0); drain();
        th[0] = 11'd81;
        send_frame(0, SMW, SMH, 0, 1'b1, SMW * SMH, 1'b0); drain();

        // Step edge: magnitude 1020 saturates.
        fill(2, SMW, SMH); th[0] = 11'd1;
        send_frame(0, SMW, SMH, 0, 1'b1, SMW * SMH, 1'b0); drain();

        // Gapped ramp: two idle cycles after every pixel.
        fill(1, SMW, SMH); th[0] = 11'd80;
        send_frame(0, SMW, SMH, 2, 1'b1, SMW * SMH, 1'b0); drain();

        // Abort after 11 pixels (the 11th completes a window), then reset with a
        // pixel presented in the reset cycle, then a clean ramp frame.
        send_frame(0, SMW, SMH, 0, 1'b0, 11, 1'b0);
        rst = 1'b1; pif[0] = 1'b1; pid[0] = 8'hAA;
        @(posedge clk); #1;
        rst = 1'b0; pif[0] = 1'b0;
        send_frame(0, SMW, SMH, 0, 1'b1, SMW * SMH, 1'b0); drain();

        // Random small frames, back to back, random gaps and thresholds.
        for (int f = 0; f < 6; f++) begin
            fill(3, SMW, SMH);
            th[0] = 11'($urandom_range(0, 1200));
            send_frame(0, SMW, SMH, (f % 2 == 0) ? -1 : 0, 1'b1, SMW * SMH, 1'b1);
        end
        drain();

        // Full-size back-to-back frames; threshold changes mid frame 1 and
        // again right at the start of frame 2.
        fill(3, LGW, LGH);
        th[1] = 11'($urandom_range(200, 1200));
        send_frame(1, LGW, LGH, 0, 1'b1, LGW * LGH, 1'b1);
        fill(3, LGW, LGH);
        th[1] = 11'($urandom_range(200, 1200));
        send_frame(1, LGW, LGH, 0, 1'b1, LGW * LGH, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
